// File: rtl/mb_boundary_ctx_pkg.sv
// Shared constants, row-word layout and FSM encoding for the macroblock
// boundary-context engine.
package mb_boundary_ctx_pkg;

  // Pixel offsets of each plane inside one packed row-RAM word {V, U, Y}.
  localparam int unsigned YOffPx = 0;
  localparam int unsigned UOffPx = 16;
  localparam int unsigned VOffPx = 24;
  localparam int unsigned WordPx = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StAsm,
    StOut
  } state_e;

  // Frame-edge substitution values: 2^(bd-1)-1 and 2^(bd-1)+1.
  function automatic int unsigned ctx_lo(int unsigned bd);
    return (32'd1 << (bd - 1)) - 32'd1;
  endfunction

  function automatic int unsigned ctx_hi(int unsigned bd);
    return (32'd1 << (bd - 1)) + 32'd1;
  endfunction

endpackage

// File: rtl/mb_row_ram.sv
// Simple dual-port row RAM: port A writes, port B reads with one cycle latency.
module mb_row_ram #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mb_boundary_ctx.sv
// Macroblock boundary-context engine: stores reconstructed edges and returns
// the intra-prediction context (top, top-right, left, top-left) per request.
module mb_boundary_ctx
  import mb_boundary_ctx_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned MB_W_MAX  = 1024,
  parameter int unsigned AW        = $clog2(MB_W_MAX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW:0]            cfg_mb_w,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_x,
  input  logic [AW-1:0]          req_y,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_x,
  input  logic [16*BIT_DEPTH-1:0] st_bot_y,
  input  logic [8*BIT_DEPTH-1:0] st_bot_u,
  input  logic [8*BIT_DEPTH-1:0] st_bot_v,
  input  logic [16*BIT_DEPTH-1:0] st_rcol_y,
  input  logic [8*BIT_DEPTH-1:0] st_rcol_u,
  input  logic [8*BIT_DEPTH-1:0] st_rcol_v,
  output logic                   ctx_valid,
  input  logic                   ctx_ready,
  output logic [20*BIT_DEPTH-1:0] ctx_top_y,
  output logic [8*BIT_DEPTH-1:0] ctx_top_u,
  output logic [8*BIT_DEPTH-1:0] ctx_top_v,
  output logic [16*BIT_DEPTH-1:0] ctx_left_y,
  output logic [8*BIT_DEPTH-1:0] ctx_left_u,
  output logic [8*BIT_DEPTH-1:0] ctx_left_v,
  output logic [BIT_DEPTH-1:0]   ctx_tl_y,
  output logic [BIT_DEPTH-1:0]   ctx_tl_u,
  output logic [BIT_DEPTH-1:0]   ctx_tl_v
);

  localparam int unsigned BD    = BIT_DEPTH;
  localparam int unsigned WordW = WordPx * BD;
  localparam logic [BD-1:0] Lo  = BD'(ctx_lo(BD));
  localparam logic [BD-1:0] Hi  = BD'(ctx_hi(BD));

  state_e           state_q;
  logic [AW-1:0]    x_q, y_q;
  logic [WordW-1:0] word_x_q;
  logic [WordW-1:0] rd_word;
  logic [AW-1:0]    rd_addr;
  logic             x_last;
  logic             st_fire, req_fire;

  logic [16*BD-1:0] left_y_q;
  logic [8*BD-1:0]  left_u_q, left_v_q;
  logic [BD-1:0]    tl_next_y_q, tl_next_u_q, tl_next_v_q;

  logic [20*BD-1:0] asm_top_y;
  logic [8*BD-1:0]  asm_top_u, asm_top_v;
  logic [16*BD-1:0] asm_left_y;
  logic [8*BD-1:0]  asm_left_u, asm_left_v;
  logic [BD-1:0]    asm_tl_y, asm_tl_u, asm_tl_v;

  assign st_ready  = (state_q == StIdle);
  assign req_ready = (state_q == StIdle) && !st_valid;
  assign st_fire   = st_valid && st_ready;
  assign req_fire  = req_valid && req_ready;
  assign x_last    = ({1'b0, x_q} == (cfg_mb_w - (AW + 1)'(1)));

  // RD0 fetches word x; RD1 fetches x+1 (or re-reads x at the right frame edge).
  always_comb begin
    rd_addr = x_q;
    if (state_q == StRd1 && !x_last) begin
      rd_addr = x_q + AW'(1);
    end
  end

  mb_row_ram #(
    .Width (WordW),
    .Depth (MB_W_MAX),
    .AddrW (AW)
  ) u_row_ram (
    .clk     (clk),
    .wr_en   (st_fire),
    .wr_addr (st_x),
    .wr_data ({st_bot_v, st_bot_u, st_bot_y}),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // Context assembly during ASM: word_x_q holds word x, rd_word holds word x+1.
  always_comb begin
    asm_top_y  = {20{Lo}};
    asm_top_u  = {8{Lo}};
    asm_top_v  = {8{Lo}};
    asm_left_y = {16{Hi}};
    asm_left_u = {8{Hi}};
    asm_left_v = {8{Hi}};
    asm_tl_y   = Lo;
    asm_tl_u   = Lo;
    asm_tl_v   = Lo;
    if (y_q != '0) begin
      asm_top_y[16*BD-1:0] = word_x_q[YOffPx*BD +: 16*BD];
      asm_top_u            = word_x_q[UOffPx*BD +: 8*BD];
      asm_top_v            = word_x_q[VOffPx*BD +: 8*BD];
      for (int i = 0; i < 4; i++) begin
        if (x_last) begin
          asm_top_y[(16+i)*BD +: BD] = word_x_q[(YOffPx+15)*BD +: BD];
        end else begin
          asm_top_y[(16+i)*BD +: BD] = rd_word[(YOffPx+i)*BD +: BD];
        end
      end
    end
    if (x_q != '0) begin
      asm_left_y = left_y_q;
      asm_left_u = left_u_q;
      asm_left_v = left_v_q;
    end
    // Top-left: above-frame is always LO, left edge below row 0 is HI.
    if (y_q == '0) begin
      asm_tl_y = Lo;
      asm_tl_u = Lo;
      asm_tl_v = Lo;
    end else if (x_q == '0) begin
      asm_tl_y = Hi;
      asm_tl_u = Hi;
      asm_tl_v = Hi;
    end else begin
      asm_tl_y = tl_next_y_q;
      asm_tl_u = tl_next_u_q;
      asm_tl_v = tl_next_v_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      word_x_q    <= '0;
      left_y_q    <= '0;
      left_u_q    <= '0;
      left_v_q    <= '0;
      tl_next_y_q <= '0;
      tl_next_u_q <= '0;
      tl_next_v_q <= '0;
      ctx_valid   <= 1'b0;
      ctx_top_y   <= '0;
      ctx_top_u   <= '0;
      ctx_top_v   <= '0;
      ctx_left_y  <= '0;
      ctx_left_u  <= '0;
      ctx_left_v  <= '0;
      ctx_tl_y    <= '0;
      ctx_tl_u    <= '0;
      ctx_tl_v    <= '0;
    end else begin
      if (st_fire) begin
        left_y_q <= st_rcol_y;
        left_u_q <= st_rcol_u;
        left_v_q <= st_rcol_v;
      end
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            x_q     <= req_x;
            y_q     <= req_y;
            state_q <= StRd0;
          end
        end
        StRd0: state_q <= StRd1;
        StRd1: begin
          word_x_q <= rd_word;
          state_q  <= StAsm;
        end
        StAsm: begin
          ctx_top_y   <= asm_top_y;
          ctx_top_u   <= asm_top_u;
          ctx_top_v   <= asm_top_v;
          ctx_left_y  <= asm_left_y;
          ctx_left_u  <= asm_left_u;
          ctx_left_v  <= asm_left_v;
          ctx_tl_y    <= asm_tl_y;
          ctx_tl_u    <= asm_tl_u;
          ctx_tl_v    <= asm_tl_v;
          // The last top sample becomes the top-left of the next column.
          tl_next_y_q <= asm_top_y[15*BD +: BD];
          tl_next_u_q <= asm_top_u[7*BD +: BD];
          tl_next_v_q <= asm_top_v[7*BD +: BD];
          ctx_valid   <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (ctx_ready) begin
            ctx_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_boundary_ctx.sv
// Scoreboard bench for mb_boundary_ctx: directed stores/requests push expected
// contexts; a negedge monitor compares whatever the DUT presents.
module tb_mb_boundary_ctx;

  localparam int BD  = 8;
  localparam int MBW = 1024;
  localparam int AW  = 10;
  // Handshake cycle T, ctx_valid seen in cycle T+4: accept edge + 3.5 periods.
  localparam longint LatT = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   cfg_mb_w;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_x, req_y;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_x;
  logic [127:0]  st_bot_y, st_rcol_y;
  logic [63:0]   st_bot_u, st_bot_v, st_rcol_u, st_rcol_v;
  logic          ctx_valid, ctx_ready;
  logic [159:0]  ctx_top_y;
  logic [63:0]   ctx_top_u, ctx_top_v, ctx_left_u, ctx_left_v;
  logic [127:0]  ctx_left_y;
  logic [7:0]    ctx_tl_y, ctx_tl_u, ctx_tl_v;

  always #5 clk = ~clk;

  mb_boundary_ctx #(.BIT_DEPTH(BD), .MB_W_MAX(MBW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mb_w(cfg_mb_w),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .st_valid(st_valid), .st_ready(st_ready), .st_x(st_x),
    .st_bot_y(st_bot_y), .st_bot_u(st_bot_u), .st_bot_v(st_bot_v),
    .st_rcol_y(st_rcol_y), .st_rcol_u(st_rcol_u), .st_rcol_v(st_rcol_v),
    .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
    .ctx_top_y(ctx_top_y), .ctx_top_u(ctx_top_u), .ctx_top_v(ctx_top_v),
    .ctx_left_y(ctx_left_y), .ctx_left_u(ctx_left_u), .ctx_left_v(ctx_left_v),
    .ctx_tl_y(ctx_tl_y), .ctx_tl_u(ctx_tl_u), .ctx_tl_v(ctx_tl_v)
  );

  typedef struct {
    logic [159:0] top_y;
    logic [63:0]  top_u, top_v;
    logic [127:0] left_y;
    logic [63:0]  left_u, left_v;
    logic [7:0]   tl_y, tl_u, tl_v;
    longint       t_acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;

  // Reference model of row memory, left registers and pending top-left.
  logic [7:0] m_y[4][16];
  logic [7:0] m_u[4][8];
  logic [7:0] m_v[4][8];
  logic [7:0] l_y[16];
  logic [7:0] l_u[8];
  logic [7:0] l_v[8];
  logic [7:0] t_y, t_u, t_v;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk)
    if (rst_n && req_valid && req_ready)
      assert ({1'b0, req_x} < cfg_mb_w) else $error("req_x out of range");

  // Monitor: compare every cycle the DUT holds a context.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (ctx_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ctx act=valid exp=none");
      end else begin
        if (!seen) begin
          chk("latency", 160'($time - q[0].t_acc), 160'(LatT));
          seen = 1'b1;
        end
        chk("top_y", ctx_top_y, q[0].top_y);
        chk("top_u", ctx_top_u, q[0].top_u);
        chk("top_v", ctx_top_v, q[0].top_v);
        chk("left_y", ctx_left_y, q[0].left_y);
        chk("left_u", ctx_left_u, q[0].left_u);
        chk("left_v", ctx_left_v, q[0].left_v);
        chk("tl", {ctx_tl_y, ctx_tl_u, ctx_tl_v}, {q[0].tl_y, q[0].tl_u, q[0].tl_v});
        chk("busy_st_ready", st_ready, 0);
        if (ctx_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  function automatic exp_t exp_ctx(int x, int y);
    exp_t e;
    e.top_y = {20{8'd127}};
    e.top_u = {8{8'd127}};
    e.top_v = {8{8'd127}};
    if (y != 0) begin
      for (int i = 0; i < 16; i++) e.top_y[i*8 +: 8] = m_y[x][i];
      for (int i = 0; i < 8; i++) begin
        e.top_u[i*8 +: 8] = m_u[x][i];
        e.top_v[i*8 +: 8] = m_v[x][i];
      end
      for (int i = 0; i < 4; i++) begin
        if (x == int'(cfg_mb_w) - 1) e.top_y[(16+i)*8 +: 8] = m_y[x][15];
        else                         e.top_y[(16+i)*8 +: 8] = m_y[x+1][i];
      end
    end
    e.left_y = {16{8'd129}};
    e.left_u = {8{8'd129}};
    e.left_v = {8{8'd129}};
    if (x != 0) begin
      for (int i = 0; i < 16; i++) e.left_y[i*8 +: 8] = l_y[i];
      for (int i = 0; i < 8; i++) begin
        e.left_u[i*8 +: 8] = l_u[i];
        e.left_v[i*8 +: 8] = l_v[i];
      end
    end
    if (y == 0) begin
      e.tl_y = 8'd127; e.tl_u = 8'd127; e.tl_v = 8'd127;
    end else if (x == 0) begin
      e.tl_y = 8'd129; e.tl_u = 8'd129; e.tl_v = 8'd129;
    end else begin
      e.tl_y = t_y; e.tl_u = t_u; e.tl_v = t_v;
    end
    e.t_acc = 0;
    return e;
  endfunction

  task automatic push_exp(input int x, input int y, input longint t);
    exp_t e;
    e = exp_ctx(x, y);
    e.t_acc = t;
    q.push_back(e);
    t_y = e.top_y[15*8 +: 8];
    t_u = e.top_u[7*8 +: 8];
    t_v = e.top_v[7*8 +: 8];
  endtask

  task automatic load_store(input int x, input int by, input int bu, input int bv,
                            input int ry, input int ru, input int rv);
    st_x = x[AW-1:0];
    for (int i = 0; i < 16; i++) begin
      st_bot_y[i*8 +: 8]  = 8'(by + i);
      st_rcol_y[i*8 +: 8] = 8'(ry + i);
      m_y[x][i] = 8'(by + i);
      l_y[i]    = 8'(ry + i);
    end
    for (int i = 0; i < 8; i++) begin
      st_bot_u[i*8 +: 8]  = 8'(bu + i);
      st_bot_v[i*8 +: 8]  = 8'(bv + i);
      st_rcol_u[i*8 +: 8] = 8'(ru + i);
      st_rcol_v[i*8 +: 8] = 8'(rv + i);
      m_u[x][i] = 8'(bu + i);
      m_v[x][i] = 8'(bv + i);
      l_u[i]    = 8'(ru + i);
      l_v[i]    = 8'(rv + i);
    end
  endtask

  task automatic do_store(input int x, input int by, input int bu, input int bv,
                          input int ry, input int ru, input int rv);
    int n;
    @(posedge clk); #1;
    load_store(x, by, bu, bv, ry, ru, rv);
    st_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!st_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("store_timeout", 1, 0);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic do_req(input int x, input int y, input bit push);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_x = x[AW-1:0];
    req_y = y[AW-1:0];
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_timeout", 1, 0);
    @(posedge clk);
    if (push) push_exp(x, y, $time);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) chk("drain_timeout", 160'(q.size()), 0);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_valid"}, ctx_valid, 0);
    chk({nm, "_outs"}, 160'(|{ctx_top_y, ctx_top_u, ctx_top_v, ctx_left_y, ctx_left_u,
                            ctx_left_v, ctx_tl_y, ctx_tl_u, ctx_tl_v}), 0);
    chk({nm, "_req_ready"}, req_ready, 1);
    chk({nm, "_st_ready"}, st_ready, 1);
  endtask

  initial begin
    longint t;
    cfg_mb_w = 11'd4;
    req_valid = 0; req_x = '0; req_y = '0;
    st_valid = 0; st_x = '0;
    st_bot_y = '0; st_bot_u = '0; st_bot_v = '0;
    st_rcol_y = '0; st_rcol_u = '0; st_rcol_v = '0;
    ctx_ready = 1'b1;
    t_y = 0; t_u = 0; t_v = 0;
    for (int i = 0; i < 16; i++) l_y[i] = 0;
    for (int i = 0; i < 8; i++) begin l_u[i] = 0; l_v[i] = 0; end
    repeat (2) @(posedge clk);
    #1 chk_idle_zero("reset");
    rst_n = 1'b1;

    // Frame origin: everything substituted.
    do_req(0, 0, 1);
    wait_drain();

    // Row 0 bottoms: Y px = 16x+i, U = 0x80+8x+i, V = 0xC0+8x+i.
    for (int x = 0; x < 4; x++) do_store(x, 16*x, 'h80 + 8*x, 'hC0 + 8*x, 'h40, 'h60, 'h70);

    // Left edge, y>0: top = word 0, top-right = 16..19, left/tl = 129.
    do_req(0, 1, 1);
    wait_drain();
    do_store(0, 'hA0, 'h10, 'h18, 'h40, 'h50, 'h58);
    // Interior: top = word 1, tr = 32..35, tl = (15, 0x87, 0xC7).
    do_req(1, 1, 1);
    wait_drain();
    do_store(1, 'hB0, 'h20, 'h28, 'h40, 'h20, 'h30);
    // Interior: top = word 2, tr = 48..51, left_y = 0x40..0x4F.
    do_req(2, 1, 1);
    wait_drain();

    // Collision: store wins, request accepted the following cycle.
    @(posedge clk); #1;
    load_store(2, 'hD0, 'h30, 'h38, 'h10, 'h08, 'h00);
    st_valid = 1'b1;
    req_valid = 1'b1; req_x = AW'(3); req_y = AW'(1);
    @(negedge clk);
    chk("coll_req_ready", req_ready, 0);
    chk("coll_st_ready", st_ready, 1);
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    chk("coll_req_ready_next", req_ready, 1);
    @(posedge clk);
    t = $time;
    // Right edge: top-right = 4 x 63, tl = (47, 0x97, 0xD7).
    push_exp(3, 1, t);
    #1 req_valid = 1'b0;
    wait_drain();

    // Backpressure: outputs held, stores blocked (checked each cycle by monitor).
    @(posedge clk); #1 ctx_ready = 1'b0;
    do_req(1, 1, 1);
    repeat (16) @(posedge clk);
    #1 ctx_ready = 1'b1;
    wait_drain();

    // Reset while in RD1 drops the request and clears outputs.
    do_req(2, 1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle_zero("midreset");
    t_y = 0; t_u = 0; t_v = 0;
    for (int i = 0; i < 16; i++) l_y[i] = 0;
    for (int i = 0; i < 8; i++) begin l_u[i] = 0; l_v[i] = 0; end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("post_reset_idle", ctx_valid, 0);
    // Cleared left and top-left registers show through at x>0, y>0.
    do_req(1, 1, 1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
